// File: rtl/alu32_issue_ctrl_if.sv
// Command and response handshake bundle for the ALU issue controller.
// master = command producer / response consumer, slave = controller.
interface alu32_issue_ctrl_if #(
    parameter int REG_AW = 3
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_op;
    logic [REG_AW-1:0] cmd_rd;
    logic [REG_AW-1:0] cmd_rs1;
    logic [REG_AW-1:0] cmd_rs2;
    logic              cmd_imm_en;
    logic [31:0]       cmd_imm;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [REG_AW-1:0] rsp_rd;
    logic [31:0]       rsp_data;
    logic [2:0]        rsp_flags;
    logic              rsp_err;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_rd,
        output cmd_rs1,
        output cmd_rs2,
        output cmd_imm_en,
        output cmd_imm,
        input  cmd_ready,
        input  rsp_valid,
        input  rsp_rd,
        input  rsp_data,
        input  rsp_flags,
        input  rsp_err,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_rd,
        input  cmd_rs1,
        input  cmd_rs2,
        input  cmd_imm_en,
        input  cmd_imm,
        output cmd_ready,
        output rsp_valid,
        output rsp_rd,
        output rsp_data,
        output rsp_flags,
        output rsp_err,
        input  rsp_ready
    );

endinterface

// File: rtl/alu32_issue_ctrl.sv
// Command front-end for an external 32-bit combinational ALU:
// register file, operand drive, writeback and response handshake.
module alu32_issue_ctrl #(
    parameter int NREGS  = 8,
    parameter int REG_AW = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    alu32_issue_ctrl_if.slave bus,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_sel,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_carry,
    input  logic        alu_overflow
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    localparam logic [3:0] OP_LOADI = 4'hF;

    state_t state;
    state_t state_nx;

    logic [31:0]       rf [NREGS];

    logic [3:0]        op_q;
    logic [REG_AW-1:0] rd_q;
    logic [REG_AW-1:0] rs1_q;
    logic [REG_AW-1:0] rs2_q;
    logic              imm_en_q;
    logic [31:0]       imm_q;

    logic [REG_AW-1:0] rsp_rd_q;
    logic [31:0]       rsp_data_q;
    logic [2:0]        rsp_flags_q;
    logic              rsp_err_q;

    logic [31:0]       rd_a;
    logic [31:0]       rd_b;
    logic              is_loadi;
    logic              is_ill;
    logic              accept;
    logic              wr_en;
    logic [31:0]       wr_data;
    logic [2:0]        res_flags;
    logic              res_err;

    // r0 is never written, but the guard keeps it zero by construction
    assign rd_a = (rs1_q == '0) ? 32'd0 : rf[rs1_q];
    assign rd_b = (rs2_q == '0) ? 32'd0 : rf[rs2_q];

    assign is_loadi = (op_q == OP_LOADI);
    assign is_ill   = (op_q >= 4'hA) && (op_q <= 4'hE);

    assign accept = (state == IDLE) && bus.cmd_valid;

    assign bus.cmd_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rd    = rsp_rd_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_flags = rsp_flags_q;
    assign bus.rsp_err   = rsp_err_q;

    always_comb begin
        state_nx  = state;
        alu_a     = 32'd0;
        alu_b     = 32'd0;
        alu_sel   = 4'd0;
        wr_en     = 1'b0;
        wr_data   = 32'd0;
        res_flags = 3'b000;
        res_err   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                state_nx = RESP;
                alu_a    = rd_a;
                alu_b    = imm_en_q ? imm_q : rd_b;
                alu_sel  = is_loadi ? 4'd0 : op_q;
                unique case (1'b1)
                    is_loadi: begin
                        wr_en     = (rd_q != '0);
                        wr_data   = imm_q;
                        res_flags = {(imm_q == 32'd0), 2'b00};
                    end
                    is_ill: begin
                        res_err = 1'b1;
                    end
                    default: begin
                        wr_en     = (rd_q != '0);
                        wr_data   = alu_result;
                        res_flags = {alu_zero, alu_carry,
                                     alu_overflow};
                    end
                endcase
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            op_q        <= 4'd0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            imm_en_q    <= 1'b0;
            imm_q       <= 32'd0;
            rsp_rd_q    <= '0;
            rsp_data_q  <= 32'd0;
            rsp_flags_q <= 3'b000;
            rsp_err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_q     <= bus.cmd_op;
                rd_q     <= bus.cmd_rd;
                rs1_q    <= bus.cmd_rs1;
                rs2_q    <= bus.cmd_rs2;
                imm_en_q <= bus.cmd_imm_en;
                imm_q    <= bus.cmd_imm;
            end
            if (state == EXEC) begin
                rsp_rd_q    <= rd_q;
                rsp_data_q  <= wr_data;
                rsp_flags_q <= res_flags;
                rsp_err_q   <= res_err;
            end
        end
    end

    // Reset wins over an EXEC writeback on the same edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                rf[i] <= 32'd0;
            end
        end else if ((state == EXEC) && wr_en) begin
            rf[rd_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_alu32_issue_ctrl.sv
// Scoreboard bench for alu32_issue_ctrl with a behavioural ALU
// and an architectural register model.
module tb_alu32_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_sel;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_carry;
    logic        alu_overflow;

    always #5 clk = ~clk;

    alu32_issue_ctrl_if #(.REG_AW(3)) bus ();

    alu32_issue_ctrl #(
        .NREGS (8),
        .REG_AW(3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_sel     (alu_sel),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .alu_carry   (alu_carry),
        .alu_overflow(alu_overflow)
    );

    typedef struct {
        logic [2:0]  rd;
        logic [31:0] data;
        logic [2:0]  flags;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m [8];
    int          cyc = 0;
    int          acc_cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] last_data;
    logic [2:0]  last_flags;

    always @(posedge clk) cyc <= cyc + 1;

    // returns {result, Z, C, V}; SUB carry = no borrow
    function automatic logic [34:0] alu_ref(
        input logic [3:0]  s,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [32:0] w;
        logic [31:0] r;
        logic        c;
        logic        v;
        r = 32'd0;
        c = 1'b0;
        v = 1'b0;
        case (s)
            4'd0: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[31:0];
                c = w[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'd1: begin
                r = a - b;
                c = (a >= b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = a << b[4:0];
            4'd6: r = a >> b[4:0];
            4'd7: r = $signed(a) >>> b[4:0];
            4'd8: r = {31'd0, $signed(a) < $signed(b)};
            4'd9: r = {31'd0, a < b};
            default: r = 32'd0;
        endcase
        return {r, (r == 32'd0), c, v};
    endfunction

    always_comb begin
        {alu_result, alu_zero, alu_carry, alu_overflow} =
            alu_ref(alu_sel, alu_a, alu_b);
    end

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send(
        input logic [3:0]  op,
        input logic [2:0]  rd,
        input logic [2:0]  rs1,
        input logic [2:0]  rs2,
        input logic        ie,
        input logic [31:0] imm
    );
        exp_t        e;
        logic [31:0] a;
        logic [31:0] b;
        logic [34:0] x;
        int          k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.cmd_ready && k < 20);
        if (!bus.cmd_ready) begin
            chk("cmd_ready_timeout", 32'd0, 32'd1);
            return;
        end
        bus.cmd_op     = op;
        bus.cmd_rd     = rd;
        bus.cmd_rs1    = rs1;
        bus.cmd_rs2    = rs2;
        bus.cmd_imm_en = ie;
        bus.cmd_imm    = imm;
        bus.cmd_valid  = 1'b1;
        acc_cyc        = cyc;
        a = m[rs1];
        b = ie ? imm : m[rs2];
        e.rd = rd;
        e.err = 1'b0;
        if (op == 4'hF) begin
            e.data  = imm;
            e.flags = {(imm == 32'd0), 2'b00};
        end else if (op > 4'd9) begin
            e.data  = 32'd0;
            e.flags = 3'b000;
            e.err   = 1'b1;
        end else begin
            x       = alu_ref(op, a, b);
            e.data  = x[34:3];
            e.flags = x[2:0];
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        chk("exec_a", alu_a, a);
        chk("exec_b", alu_b, b);
        chk("exec_sel", {28'd0, alu_sel},
            {28'd0, (op == 4'hF) ? 4'd0 : op});
        exp_q.push_back(e);
        if (!e.err && rd != 3'd0) m[rd] = e.data;
    endtask

    task automatic recv(input int hold);
        exp_t e;
        int   k;
        k = 0;
        while (!bus.rsp_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!bus.rsp_valid) begin
            chk("rsp_timeout", 32'd0, 32'd1);
            return;
        end
        chk("latency", cyc - acc_cyc, 32'd2);
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        chk("rsp_rd", {29'd0, bus.rsp_rd}, {29'd0, e.rd});
        chk("rsp_data", bus.rsp_data, e.data);
        chk("rsp_flags", {29'd0, bus.rsp_flags}, {29'd0, e.flags});
        chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
        last_data  = bus.rsp_data;
        last_flags = bus.rsp_flags;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
            chk("hold_data", bus.rsp_data, e.data);
            chk("hold_flags", {29'd0, bus.rsp_flags},
                {29'd0, e.flags});
            chk("hold_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
            chk("hold_alu_sel", {28'd0, alu_sel}, 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rsp_done", {31'd0, bus.rsp_valid}, 32'd0);
        chk("ready_after", {31'd0, bus.cmd_ready}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = 4'd0;
        bus.cmd_rd     = 3'd0;
        bus.cmd_rs1    = 3'd0;
        bus.cmd_rs2    = 3'd0;
        bus.cmd_imm_en = 1'b0;
        bus.cmd_imm    = 32'd0;
        bus.rsp_ready  = 1'b1;
        for (int i = 0; i < 8; i++) m[i] = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        chk("rst_rsp_flags", {29'd0, bus.rsp_flags}, 32'd0);
        chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        chk("rst_alu_sel", {28'd0, alu_sel}, 32'd0);
        rst_n = 1'b1;

        send(4'hF, 3'd1, 3'd0, 3'd0, 1'b0, 32'd5);
        recv(0);
        send(4'hF, 3'd2, 3'd0, 3'd0, 1'b0, 32'd7);
        recv(0);
        send(4'd0, 3'd3, 3'd1, 3'd2, 1'b0, 32'd0);
        recv(0);
        chk("add_12", last_data, 32'd12);
        chk("add_flags", {29'd0, last_flags}, 32'd0);

        send(4'd1, 3'd4, 3'd1, 3'd2, 1'b0, 32'd0);
        recv(0);
        chk("sub_neg", last_data, 32'hFFFF_FFFE);
        chk("sub_neg_flags", {29'd0, last_flags}, 32'd0);
        send(4'd1, 3'd5, 3'd1, 3'd1, 1'b0, 32'd0);
        recv(0);
        chk("sub_zero", last_data, 32'd0);
        chk("sub_zero_flags", {29'd0, last_flags}, 32'd6);

        send(4'hF, 3'd6, 3'd0, 3'd0, 1'b0, 32'h7FFF_FFFF);
        recv(0);
        send(4'd0, 3'd6, 3'd6, 3'd0, 1'b1, 32'd1);
        recv(0);
        chk("ovf_data", last_data, 32'h8000_0000);
        chk("ovf_flags", {29'd0, last_flags}, 32'd1);
        send(4'd0, 3'd7, 3'd6, 3'd0, 1'b1, 32'd0);
        recv(0);
        chk("raw_r6", last_data, 32'h8000_0000);

        bus.rsp_ready = 1'b0;
        send(4'd2, 3'd7, 3'd1, 3'd2, 1'b0, 32'd0);
        recv(5);

        send(4'd4, 3'd7, 3'd4, 3'd2, 1'b0, 32'd0);
        recv(0);
        send(4'd7, 3'd7, 3'd6, 3'd0, 1'b1, 32'd4);
        recv(0);
        send(4'd8, 3'd7, 3'd4, 3'd1, 1'b0, 32'd0);
        recv(0);
        send(4'd9, 3'd7, 3'd4, 3'd1, 1'b0, 32'd0);
        recv(0);

        send(4'hA, 3'd3, 3'd1, 3'd2, 1'b0, 32'd0);
        recv(0);
        send(4'd0, 3'd0, 3'd3, 3'd0, 1'b1, 32'd0);
        recv(0);
        chk("r3_kept", last_data, 32'd12);
        send(4'hF, 3'd0, 3'd0, 3'd0, 1'b0, 32'd9);
        recv(0);
        send(4'd0, 3'd7, 3'd0, 3'd0, 1'b0, 32'd0);
        recv(0);
        chk("r0_zero", last_data, 32'd0);
        chk("r0_zflag", {31'd0, last_flags[2]}, 32'd1);

        send(4'd0, 3'd3, 3'd1, 3'd2, 1'b0, 32'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 8; i++) m[i] = 32'd0;
        for (int i = 0; i < 3; i++) begin
            chk("rr_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
            chk("rr_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
            @(posedge clk);
            #1;
        end
        for (int i = 1; i < 8; i++) begin
            send(4'd0, 3'd0, 3'(i), 3'd0, 1'b1, 32'd0);
            recv(0);
            chk("rr_reg_clear", last_data, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
